pipe_ctrl: RTL and testbench

//  Pipeline sequencer for the 5-stage core around the decode stage. Generates per-stage

---
 rtl/pipe_ctrl_pkg.sv | 37 +++
 rtl/pipe_ctrl_hazard_detect.sv | 28 ++
 rtl/pipe_ctrl.sv | 133 +++++++++++++
 tb/tb_pipe_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipes: shared types for the decode-side pipeline sequencer.
//   ctrl_state_t    - sequencer state (normal run / redirect waiting on fetch)
//   pipe_ctrl_out_t - stall/flush bits, grouped for pipeline register hookup
// -----------------------------------------------------------------------------
package pipes;

    typedef enum logic [0:0] {
        RUN        = 1'b0,
        REDIR_PEND = 1'b1
    } ctrl_state_t;

    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic stall_e;
        logic stall_m;
        logic flush_d;
        logic flush_e;
        logic flush_w;
    } pipe_ctrl_out_t;

    localparam pipe_ctrl_out_t CTRL_IDLE = '0;

    // Data memory still busy: freeze F..M and drain a bubble into W.
    localparam pipe_ctrl_out_t CTRL_MEM_WAIT = '{
        stall_f: 1'b1, stall_d: 1'b1, stall_e: 1'b1, stall_m: 1'b1,
        flush_d: 1'b0, flush_e: 1'b0, flush_w: 1'b1
    };

    // Load-use hazard: hold F and D, send a bubble into E.
    localparam pipe_ctrl_out_t CTRL_LOAD_USE = '{
        stall_f: 1'b1, stall_d: 1'b1, stall_e: 1'b0, stall_m: 1'b0,
        flush_d: 1'b0, flush_e: 1'b1, flush_w: 1'b0
    };

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect: combinational load-use hazard compare between decode and
// execute.
//   d_valid, rs1, rs2          - decode instruction and its source registers
//   e_valid, e_is_load, e_dst  - execute instruction, load flag, destination
//   load_use                   - decode needs a value the load in E has not
//                                produced yet
// -----------------------------------------------------------------------------
module hazard_detect (
    input  logic       d_valid,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic       e_valid,
    input  logic       e_is_load,
    input  logic [4:0] e_dst,
    output logic       load_use
);

    always_comb begin
        load_use = 1'b0;
        // x0 is hardwired to zero, so a load "writing" it never creates a hazard.
        if (e_valid && e_is_load && (e_dst != 5'd0) && d_valid &&
            ((e_dst == rs1) || (e_dst == rs2))) begin
            load_use = 1'b1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl: pipeline sequencer beside the decode stage of the 5-stage core.
// Produces per-stage stall/flush, inserts load-use bubbles and issues PC
// redirects for control transfers resolved in decode. A redirect that meets a
// busy fetch is parked in pend_pc until fetch is free.
//   clk, reset                 - core clock, synchronous active-high reset
//   d_valid, rs1, rs2          - decode instruction and source registers
//   branch, pcbranch           - decode resolved a taken transfer, its target
//   e_valid, e_is_load, e_dst  - execute stage instruction info
//   i_busy, d_busy             - fetch / data memory request outstanding
//   stall_f/d/e/m              - hold F/D, D/E, E/M, M/W registers
//   flush_d/e/w                - load bubble into D, E, W registers
//   redirect_valid/pc          - one-cycle fetch redirect and its target
//   stall_cycles               - running count of cycles with stall_d=1
// Priority: d_busy > load-use > branch.
// -----------------------------------------------------------------------------
module pipe_ctrl
    import pipes::*;
#(
    parameter int ADDR_W = 64,
    parameter int CNT_W  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              d_valid,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic              branch,
    input  logic [ADDR_W-1:0] pcbranch,
    input  logic              e_valid,
    input  logic              e_is_load,
    input  logic [4:0]        e_dst,
    input  logic              i_busy,
    input  logic              d_busy,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              stall_m,
    output logic              flush_d,
    output logic              flush_e,
    output logic              flush_w,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic [CNT_W-1:0]  stall_cycles
);

    ctrl_state_t       state_q, state_d;
    logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
    logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;

    pipe_ctrl_out_t    ctrl;
    logic              load_use;

    hazard_detect u_hazard_detect (
        .d_valid   (d_valid),
        .rs1       (rs1),
        .rs2       (rs2),
        .e_valid   (e_valid),
        .e_is_load (e_is_load),
        .e_dst     (e_dst),
        .load_use  (load_use)
    );

    always_comb begin
        state_d        = state_q;
        pend_pc_d      = pend_pc_q;
        ctrl           = CTRL_IDLE;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // Outputs are forced quiet while reset is held so nothing leaks
        // into the pipeline from inputs sampled during reset.
        if (!reset) begin
            if (d_busy) begin
                // Memory wait freezes everything; a pending redirect stays parked
                // and a branch in decode is simply seen again later.
                ctrl = CTRL_MEM_WAIT;
                if (state_q == REDIR_PEND) begin
                    ctrl.flush_d = 1'b1;
                end
            end else if (state_q == REDIR_PEND) begin
                // Whatever fetch delivers now is wrong-path, so D is killed
                // every cycle until the redirect goes out.
                ctrl.flush_d = 1'b1;
                if (i_busy) begin
                    ctrl.stall_f = 1'b1;
                end else begin
                    redirect_valid = 1'b1;
                    redirect_pc    = pend_pc_q;
                    state_d        = RUN;
                end
            end else if (load_use) begin
                // A branch in decode is ignored here; decode is held so the
                // branch is re-evaluated next cycle.
                ctrl = CTRL_LOAD_USE;
            end else if (d_valid && branch) begin
                ctrl.flush_d = 1'b1;
                if (i_busy) begin
                    ctrl.stall_f = 1'b1;
                    pend_pc_d    = pcbranch;
                    state_d      = REDIR_PEND;
                end else begin
                    redirect_valid = 1'b1;
                    redirect_pc    = pcbranch;
                end
            end
        end

        stall_cycles_d = stall_cycles_q + {{(CNT_W-1){1'b0}}, ctrl.stall_d};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= RUN;
            pend_pc_q      <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            pend_pc_q      <= pend_pc_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_f      = ctrl.stall_f;
    assign stall_d      = ctrl.stall_d;
    assign stall_e      = ctrl.stall_e;
    assign stall_m      = ctrl.stall_m;
    assign flush_d      = ctrl.flush_d;
    assign flush_e      = ctrl.flush_e;
    assign flush_w      = ctrl.flush_w;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

    localparam int ADDR_W = 64;
    localparam int CNT_W  = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              d_valid;
    logic [4:0]        rs1, rs2;
    logic              branch;
    logic [ADDR_W-1:0] pcbranch;
    logic              e_valid, e_is_load;
    logic [4:0]        e_dst;
    logic              i_busy, d_busy;
    logic              stall_f, stall_d, stall_e, stall_m;
    logic              flush_d, flush_e, flush_w;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic [CNT_W-1:0]  stall_cycles;

    int n_cmp = 0;
    int n_bad = 0;
    logic [CNT_W-1:0] exp_cnt;

    always #5 clk = ~clk;

    pipe_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .d_valid(d_valid), .rs1(rs1), .rs2(rs2),
        .branch(branch), .pcbranch(pcbranch), .e_valid(e_valid),
        .e_is_load(e_is_load), .e_dst(e_dst), .i_busy(i_busy), .d_busy(d_busy),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
        .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stall_cycles(stall_cycles)
    );

    // ctrl bit order: {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w}
    typedef struct {
        string             name;
        logic              d_valid;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic              branch;
        logic [ADDR_W-1:0] pcbranch;
        logic              e_valid;
        logic              e_is_load;
        logic [4:0]        e_dst;
        logic              i_busy;
        logic              d_busy;
        logic [6:0]        exp_ctrl;
        logic              exp_rv;
        logic [ADDR_W-1:0] exp_pc;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    function automatic vec_t mk(input string nm, input logic dv, input logic [4:0] r1,
                                input logic [4:0] r2, input logic br, input logic [ADDR_W-1:0] pc,
                                input logic ev, input logic el, input logic [4:0] ed,
                                input logic ib, input logic db, input logic [6:0] ec,
                                input logic erv, input logic [ADDR_W-1:0] epc);
        vec_t v;
        v.name = nm; v.d_valid = dv; v.rs1 = r1; v.rs2 = r2; v.branch = br;
        v.pcbranch = pc; v.e_valid = ev; v.e_is_load = el; v.e_dst = ed;
        v.i_busy = ib; v.d_busy = db; v.exp_ctrl = ec; v.exp_rv = erv; v.exp_pc = epc;
        return v;
    endfunction

    task automatic drive(input logic dv, input logic [4:0] r1, input logic [4:0] r2,
                         input logic br, input logic [ADDR_W-1:0] pc, input logic ev,
                         input logic el, input logic [4:0] ed, input logic ib, input logic db);
        d_valid = dv; rs1 = r1; rs2 = r2; branch = br; pcbranch = pc;
        e_valid = ev; e_is_load = el; e_dst = ed; i_busy = ib; d_busy = db;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 1'b0, '0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    // Called #1 after a negedge with inputs already applied.
    task automatic chk(input string nm, input logic [6:0] ec, input logic erv,
                       input logic [ADDR_W-1:0] epc, input bit do_cnt);
        logic [6:0] act;
        act = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w};
        n_cmp++;
        if (act !== ec) begin
            n_bad++;
            $display("FAIL %s ctrl: got %b want %b", nm, act, ec);
        end
        n_cmp++;
        if (redirect_valid !== erv) begin
            n_bad++;
            $display("FAIL %s redirect_valid: got %b want %b", nm, redirect_valid, erv);
        end
        n_cmp++;
        if (redirect_pc !== epc) begin
            n_bad++;
            $display("FAIL %s redirect_pc: got %h want %h", nm, redirect_pc, epc);
        end
        if (do_cnt) begin
            n_cmp++;
            if (stall_cycles !== exp_cnt) begin
                n_bad++;
                $display("FAIL %s stall_cycles: got %0d want %0d", nm, stall_cycles, exp_cnt);
            end
            exp_cnt = exp_cnt + {{(CNT_W-1){1'b0}}, ec[5]};
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = mk("idle",         0, 0, 0, 0, '0,            0, 0, 0, 0, 0, 7'b0000000, 0, '0);
        vecs[1]  = mk("lu_rs1",       1, 5, 3, 0, '0,            1, 1, 5, 0, 0, 7'b1100010, 0, '0);
        vecs[2]  = mk("lu_x0",        1, 0, 3, 0, '0,            1, 1, 0, 0, 0, 7'b0000000, 0, '0);
        vecs[3]  = mk("lu_rs2",       1, 1, 7, 0, '0,            1, 1, 7, 0, 0, 7'b1100010, 0, '0);
        vecs[4]  = mk("not_load",     1, 5, 3, 0, '0,            1, 0, 5, 0, 0, 7'b0000000, 0, '0);
        vecs[5]  = mk("e_invalid",    1, 5, 3, 0, '0,            0, 1, 5, 0, 0, 7'b0000000, 0, '0);
        vecs[6]  = mk("d_invalid",    0, 5, 3, 0, '0,            1, 1, 5, 0, 0, 7'b0000000, 0, '0);
        vecs[7]  = mk("br_now",       1, 1, 2, 1, 64'h8000_0040, 0, 0, 0, 0, 0, 7'b0000100, 1, 64'h8000_0040);
        vecs[8]  = mk("br_no_dvalid", 0, 1, 2, 1, 64'h8000_0040, 0, 0, 0, 0, 0, 7'b0000000, 0, '0);
        vecs[9]  = mk("dbusy",        0, 0, 0, 0, '0,            0, 0, 0, 0, 1, 7'b1111001, 0, '0);
        vecs[10] = mk("dbusy_all",    1, 4, 0, 1, 64'h1234,      1, 1, 4, 0, 1, 7'b1111001, 0, '0);
        vecs[11] = mk("lu_over_br",   1, 4, 0, 1, 64'h1234,      1, 1, 4, 0, 0, 7'b1100010, 0, '0);

        // Test 1: reset with a branch present
        drive(1'b1, 5'd1, 5'd2, 1'b1, 64'h8000_0040, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            chk("reset_hold", 7'b0, 1'b0, '0, 1'b0);
        end
        @(negedge clk);
        reset = 1'b0;
        idle();
        exp_cnt = '0;
        #1;
        chk("after_reset", 7'b0, 1'b0, '0, 1'b1);

        // Single-cycle table in RUN
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].d_valid, vecs[i].rs1, vecs[i].rs2, vecs[i].branch, vecs[i].pcbranch,
                  vecs[i].e_valid, vecs[i].e_is_load, vecs[i].e_dst, vecs[i].i_busy, vecs[i].d_busy);
            #1;
            chk(vecs[i].name, vecs[i].exp_ctrl, vecs[i].exp_rv, vecs[i].exp_pc, 1'b1);
        end

        // Test 4: redirect held while fetch busy for 3 cycles
        @(negedge clk);
        drive(1'b1, 5'd1, 5'd2, 1'b1, 64'h8000_0100, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        #1; chk("pend_enter", 7'b1000100, 1'b0, '0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive(1'b1, 5'd1, 5'd2, 1'b0, '0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
            #1; chk("pend_wait", 7'b1000100, 1'b0, '0, 1'b1);
        end
        @(negedge clk);
        i_busy = 1'b0;
        #1; chk("pend_fire", 7'b0000100, 1'b1, 64'h8000_0100, 1'b1);
        @(negedge clk);
        idle();
        #1; chk("pend_back_run", 7'b0, 1'b0, '0, 1'b1);

        // Test 5: d_busy over load-use over branch, then each in turn
        @(negedge clk);
        drive(1'b1, 5'd9, 5'd3, 1'b1, 64'h8000_0200, 1'b1, 1'b1, 5'd9, 1'b0, 1'b1);
        #1; chk("prio_dbusy", 7'b1111001, 1'b0, '0, 1'b1);
        @(negedge clk);
        d_busy = 1'b0;
        #1; chk("prio_lu", 7'b1100010, 1'b0, '0, 1'b1);
        @(negedge clk);
        e_valid = 1'b0; e_is_load = 1'b0; e_dst = 5'd0;
        #1; chk("prio_br", 7'b0000100, 1'b1, 64'h8000_0200, 1'b1);

        // Test 6: reset while a redirect is pending discards it
        @(negedge clk);
        drive(1'b1, 5'd1, 5'd2, 1'b1, 64'h8000_0300, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        #1; chk("pend_before_rst", 7'b1000100, 1'b0, '0, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        idle();
        #1; chk("pend_in_rst", 7'b0, 1'b0, '0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        exp_cnt = '0;
        #1; chk("post_rst_no_redir", 7'b0, 1'b0, '0, 1'b1);
        @(negedge clk);
        #1; chk("post_rst_idle", 7'b0, 1'b0, '0, 1'b1);
        // Counter restarts from 0 after reset
        @(negedge clk);
        drive(1'b1, 5'd6, 5'd0, 1'b0, '0, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0);
        #1; chk("post_rst_lu", 7'b1100010, 1'b0, '0, 1'b1);
        @(negedge clk);
        idle();
        #1; chk("post_rst_cnt", 7'b0, 1'b0, '0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
